// File: rtl/trigger_detector.sv
// Trigger-condition engine: arm / pre-trigger / armed / done sequencing with a
// combined level-and-edge match, registered one-cycle trigger pulse and position.
module trigger_detector #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] trig_mask,
    input  logic [DATA_WIDTH-1:0] trig_value,
    input  logic [DATA_WIDTH-1:0] rise_mask,
    input  logic [DATA_WIDTH-1:0] fall_mask,
    input  logic [CNT_WIDTH-1:0]  pre_count,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  armed,
    output logic                  done,
    output logic                  trig_pulse,
    output logic [CNT_WIDTH-1:0]  trig_pos
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRETRIG = 2'd1,
        ST_ARMED   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                  state_r, state_s;
    logic [DATA_WIDTH-1:0]   mask_r, value_r, rise_r, fall_r, prev_r;
    logic [CNT_WIDTH-1:0]    pre_count_r, pre_cnt_r, sample_cnt_r;
    logic                    level_ok_s, edge_hit_s, edge_ok_s, trig_cond_s;
    logic                    arm_ok_s, fire_s;

    // Trigger condition on the live sample against the configuration latched at arm
    always_comb begin
        level_ok_s  = (((data_in ^ value_r) & mask_r) == DATA_ZERO);
        edge_hit_s  = |((rise_r & data_in & ~prev_r) | (fall_r & ~data_in & prev_r));
        edge_ok_s   = edge_hit_s | ((rise_r | fall_r) == DATA_ZERO);
        trig_cond_s = level_ok_s & edge_ok_s;
    end

    // Next-state logic; abort outranks a trigger, which outranks arm
    always_comb begin
        state_s  = state_r;
        arm_ok_s = 1'b0;
        fire_s   = 1'b0;
        if (abort) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (arm) begin
                        arm_ok_s = 1'b1;
                        state_s  = (pre_count != CNT_ZERO) ? ST_PRETRIG : ST_ARMED;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_PRETRIG: begin
                    if (pre_cnt_r == (pre_count_r - CNT_ONE)) begin
                        state_s = ST_ARMED;
                    end else begin
                        state_s = ST_PRETRIG;
                    end
                end
                ST_ARMED: begin
                    if (trig_cond_s) begin
                        fire_s  = 1'b1;
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ARMED;
                    end
                end
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: config latch, counters, sample delay and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r       <= DATA_ZERO;
            value_r      <= DATA_ZERO;
            rise_r       <= DATA_ZERO;
            fall_r       <= DATA_ZERO;
            pre_count_r  <= CNT_ZERO;
            pre_cnt_r    <= CNT_ZERO;
            sample_cnt_r <= CNT_ZERO;
            prev_r       <= DATA_ZERO;
            data_out     <= DATA_ZERO;
            armed        <= 1'b0;
            done         <= 1'b0;
            trig_pulse   <= 1'b0;
            trig_pos     <= CNT_ZERO;
        end else begin
            prev_r     <= data_in;
            data_out   <= data_in;
            armed      <= (state_s == ST_PRETRIG) || (state_s == ST_ARMED);
            done       <= (state_s == ST_DONE);
            trig_pulse <= fire_s;
            if (fire_s) begin
                trig_pos <= sample_cnt_r;
            end else begin
                trig_pos <= trig_pos;
            end
            if (arm_ok_s) begin
                mask_r       <= trig_mask;
                value_r      <= trig_value;
                rise_r       <= rise_mask;
                fall_r       <= fall_mask;
                pre_count_r  <= pre_count;
                pre_cnt_r    <= CNT_ZERO;
                sample_cnt_r <= CNT_ZERO;
            end else begin
                // sample index saturates rather than wrapping on very long waits
                if (((state_r == ST_PRETRIG) || (state_r == ST_ARMED)) && (sample_cnt_r != CNT_MAX)) begin
                    sample_cnt_r <= sample_cnt_r + CNT_ONE;
                end else begin
                    sample_cnt_r <= sample_cnt_r;
                end
                if (state_r == ST_PRETRIG) begin
                    pre_cnt_r <= pre_cnt_r + CNT_ONE;
                end else begin
                    pre_cnt_r <= pre_cnt_r;
                end
            end
        end
    end

endmodule
